mux_rr_arbiter: RTL and testbench

// - Round-robin arbiter that shares one 4:1 nibble mux between four requesters.
// - Each requester presents a 4-bit word and a request line.
// - The block grants one requester at a time and drives the mux select.
// - It presents the granted word on a single shared output with a valid flag.
// - It sits between the requesting agents and the downstream consumer of the

---
 rtl/mux_arb_pkg.sv | 34 +++
 rtl/mux_rr_arbiter_mux.sv | 26 ++
 rtl/mux_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin nibble-mux arbiter.
//   arb_state_t : arbiter FSM states
//   N_REQ       : number of requesters sharing the mux
//   rr_pick     : round-robin winner search starting after last_ptr
package mux_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // Candidates are checked in the order last_ptr+1, +2, +3, +4 (mod 4).
  // The loop runs from the farthest candidate to the nearest so that the
  // nearest asserted request overwrites the result last and wins.
  function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] req,
                                       input logic [1:0]       last_ptr);
    rr_pick_t   pick;
    logic [1:0] idx;
    pick = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = last_ptr + 2'(k);
      if (req[idx]) begin
        pick.found = 1'b1;
        pick.idx   = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Plain 4:1 word mux used as the shared datapath of the arbiter.
//   in0..in3 : candidate words
//   sel      : index of the word to pass through
//   raw      : selected word (purely combinational)
module mux_rr_arbiter_mux #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] raw
);

  always_comb begin
    raw = in0;
    case (sel)
      2'd0:    raw = in0;
      2'd1:    raw = in1;
      2'd2:    raw = in2;
      default: raw = in3;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 nibble mux between four requesters.
//   clk      : clock, all state changes on the rising edge
//   reset    : synchronous active-high reset
//   req      : request lines, req[i] owns in<i>
//   in0..in3 : requester words
//   gnt      : registered one-hot grant, zero when idle
//   select   : registered mux select (current or last grant index)
//   valid    : registered, high exactly when gnt is non-zero
//   out      : granted word, zero while valid is low
// A requester may keep the grant indefinitely when nobody else asks; under
// contention it is released after MAX_HOLD consecutive cycles.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       gnt,
  output logic [1:0]       select,
  output logic             valid,
  output logic [WIDTH-1:0] out
);

  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t       state_q;
  logic [3:0]       gnt_q;
  logic [1:0]       select_q;
  logic             valid_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [1:0]       last_ptr_q;

  logic [3:0]       other_req_d;
  rr_pick_t         pick_all_d;
  rr_pick_t         pick_other_d;
  logic [WIDTH-1:0] raw_d;

  // In GRANT, gnt_q is the one-hot of the current owner, so masking with it
  // leaves only the competing requests.
  always_comb begin
    other_req_d  = req & ~gnt_q;
    pick_all_d   = rr_pick(req, last_ptr_q);
    pick_other_d = rr_pick(other_req_d, last_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      select_q   <= '0;
      valid_q    <= 1'b0;
      hold_cnt_q <= '0;
      last_ptr_q <= 2'd3;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_all_d.found) begin
            state_q    <= GRANT;
            gnt_q      <= 4'(1) << pick_all_d.idx;
            select_q   <= pick_all_d.idx;
            valid_q    <= 1'b1;
            last_ptr_q <= pick_all_d.idx;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (req[select_q]) begin
            if (other_req_d == '0) begin
              // Uncontended: keep the grant, counter parks at its top value.
              if (hold_cnt_q != HOLD_LAST) hold_cnt_q <= hold_cnt_q + 1'b1;
            end else if (hold_cnt_q != HOLD_LAST) begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end else begin
              // Hold budget spent: hand over straight to the next contender.
              gnt_q      <= 4'(1) << pick_other_d.idx;
              select_q   <= pick_other_d.idx;
              last_ptr_q <= pick_other_d.idx;
              hold_cnt_q <= '0;
            end
          end else if (pick_all_d.found) begin
            // Owner released while others wait: no idle bubble.
            gnt_q      <= 4'(1) << pick_all_d.idx;
            select_q   <= pick_all_d.idx;
            last_ptr_q <= pick_all_d.idx;
            hold_cnt_q <= '0;
          end else begin
            // Nobody asking: drop the grant but remember select/last_ptr.
            state_q    <= IDLE;
            gnt_q      <= '0;
            valid_q    <= 1'b0;
            hold_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  mux_rr_arbiter_mux #(.WIDTH(WIDTH)) u_mux (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .sel (select_q),
    .raw (raw_d)
  );

  assign gnt    = gnt_q;
  assign select = select_q;
  assign valid  = valid_q;
  assign out    = valid_q ? raw_d : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a behavioural model predicts each
// cycle's outputs into a scoreboard queue, which is popped and compared after
// the following clock edge. Directed scenarios also carry hand-written grants.
module tb_mux_rr_arbiter;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  logic             clk;
  logic             reset;
  logic [3:0]       req;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic [3:0]       gnt;
  logic [1:0]       select;
  logic             valid;
  logic [WIDTH-1:0] out;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .in0    (in0),
    .in1    (in1),
    .in2    (in2),
    .in3    (in3),
    .gnt    (gnt),
    .select (select),
    .valid  (valid),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       gnt;
    logic [1:0]       select;
    logic             valid;
    logic [WIDTH-1:0] out;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // model state
  bit m_busy;
  int m_sel;
  int m_last;
  int m_age;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int search(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] word(input int i);
    case (i)
      0: return in0;
      1: return in1;
      2: return in2;
      default: return in3;
    endcase
  endfunction

  // Advance the model by one edge and return its predicted outputs.
  function automatic exp_t model_step(input logic rst, input logic [3:0] r);
    exp_t e;
    int   w;
    logic [3:0] others;
    if (rst) begin
      m_busy = 0; m_sel = 0; m_last = 3; m_age = 0;
    end else if (!m_busy) begin
      w = search(r, m_last);
      if (w >= 0) begin m_busy = 1; m_sel = w; m_last = w; m_age = 0; end
    end else begin
      others = r & ~(4'b0001 << m_sel);
      if (r[m_sel] && others == 0) begin
        if (m_age < MAX_HOLD - 1) m_age++;
      end else if (r[m_sel] && m_age < MAX_HOLD - 1) begin
        m_age++;
      end else begin
        w = r[m_sel] ? search(others, m_last) : search(r, m_last);
        if (w >= 0) begin m_sel = w; m_last = w; m_age = 0; end
        else begin m_busy = 0; m_age = 0; end
      end
    end
    e.gnt    = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    e.select = 2'(m_sel);
    e.valid  = m_busy;
    e.out    = m_busy ? word(m_sel) : '0;
    return e;
  endfunction

  // One transaction: drive, predict, clock, compare. spec_gnt < 0 means no
  // hand-written grant expectation for this cycle.
  task automatic cyc(input logic rst, input logic [3:0] r, input int spec_gnt);
    exp_t e;
    reset = rst;
    req   = r;
    sb_q.push_back(model_step(rst, r));
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val("gnt", 32'(gnt), 32'(e.gnt));
      check_val("select", 32'(select), 32'(e.select));
      check_val("valid", 32'(valid), 32'(e.valid));
      check_val("out", 32'(out), 32'(e.out));
    end
    if (spec_gnt >= 0) check_val("spec_gnt", 32'(gnt), 32'(spec_gnt));
    $display("t=%0t rst=%b req=%b gnt=%b sel=%0d valid=%b out=%h",
             $time, rst, r, gnt, select, valid, out);
  endtask

  initial begin
    reset = 1'b1; req = 4'b1111;
    in0 = 4'hC; in1 = 4'hD; in2 = 4'hE; in3 = 4'hF;
    m_busy = 0; m_sel = 0; m_last = 3; m_age = 0;

    // reset held with all requests asserted
    for (int i = 0; i < 2; i++) cyc(1'b1, 4'b1111, 0);
    check_val("rst_out", 32'(out), 32'h0);

    // lone requester 2 keeps the grant, no forced release
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'b0100, 4'b0100);
    check_val("lone_out", 32'(out), 32'hE);
    check_val("lone_sel", 32'(select), 32'd2);

    // full contention: rotate every MAX_HOLD cycles, valid never drops
    cyc(1'b1, 4'b0000, 0);
    for (int k = 0; k < 20; k++)
      cyc(1'b0, 4'b1111, 4'b0001 << ((k / MAX_HOLD) % 4));

    // owner 1 drops while 3 waits: direct handover
    cyc(1'b1, 4'b0000, 0);
    cyc(1'b0, 4'b0010, 4'b0010);
    cyc(1'b0, 4'b0010, 4'b0010);
    cyc(1'b0, 4'b1000, 4'b1000);
    check_val("handover_out", 32'(out), 32'hF);

    // all drop while 2 owns, then 0101 wraps to 0
    cyc(1'b1, 4'b0000, 0);
    cyc(1'b0, 4'b0100, 4'b0100);
    cyc(1'b0, 4'b0000, 0);
    check_val("idle_out", 32'(out), 32'h0);
    cyc(1'b0, 4'b0101, 4'b0001);

    // reset pulse mid-grant, then 0 wins first
    cyc(1'b0, 4'b0100, 4'b0100);
    cyc(1'b0, 4'b0100, 4'b0100);
    cyc(1'b1, 4'b0100, 0);
    cyc(1'b0, 4'b1111, 4'b0001);

    // granted input changes are visible in the same cycle
    in0 = 4'h3;
    #1 check_val("live_out", 32'(out), 32'h3);

    // random traffic with occasional reset and changing data
    for (int i = 0; i < 300; i++) begin
      in0 = 4'($urandom); in1 = 4'($urandom);
      in2 = 4'($urandom); in3 = 4'($urandom);
      cyc(($urandom_range(0, 39) == 0), 4'($urandom), -1);
    end

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
